// File: rtl/dram_cache_mem_responder_if.sv
// Bus bundle between the DRAM cache controller's m_* ports and the memory-side responder.
// The slave modport is the responder's view; the master modport is the controller's view.
interface dram_cache_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int TAG_SIZE   = 16
);
    logic [ID_WIDTH-1:0]            arid_i;
    logic [ADDR_WIDTH-1:0]          araddr_i;
    logic                           arvalid_i;
    logic                           arready_o;
    logic [ID_WIDTH-1:0]            rid_o;
    logic [TAG_SIZE+DATA_WIDTH-1:0] rdata_o;
    logic                           rvalid_o;
    logic                           rready_i;
    logic [ID_WIDTH-1:0]            awid_i;
    logic [ADDR_WIDTH-1:0]          awaddr_i;
    logic                           awvalid_i;
    logic                           awready_o;
    logic [ID_WIDTH-1:0]            wid_i;
    logic [DATA_WIDTH-1:0]          wdata_i;
    logic                           wvalid_i;
    logic                           wready_o;

    modport slave (
        input  arid_i, araddr_i, arvalid_i, rready_i,
        input  awid_i, awaddr_i, awvalid_i, wid_i, wdata_i, wvalid_i,
        output arready_o, rid_o, rdata_o, rvalid_o, awready_o, wready_o
    );

    modport master (
        output arid_i, araddr_i, arvalid_i, rready_i,
        output awid_i, awaddr_i, awvalid_i, wid_i, wdata_i, wvalid_i,
        input  arready_o, rid_o, rdata_o, rvalid_o, awready_o, wready_o
    );
endinterface

// File: rtl/dram_cache_mem_responder.sv
// Direct-mapped {valid, tag, data} DRAM model: fixed-latency in-order reads, AW/W fill commits.
// Define MEM_RESP_STALL_EN to inject periodic ready/valid stalls from a free-running 3-bit counter.
module dram_cache_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int ID_WIDTH     = 4,
    parameter int TAG_SIZE     = 16,
    parameter int INDEX_WIDTH  = 10,
    parameter int OFFSET_WIDTH = 6,
    parameter int RD_LATENCY   = 4,
    parameter int RD_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dram_cache_mem_responder_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int RDATA_W = TAG_SIZE + DATA_WIDTH;
    localparam int LINE_W  = TAG_SIZE + INDEX_WIDTH;
    localparam int PTR_W   = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RD_DEPTH + 1);
    localparam int AGE_W   = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RD_DEPTH);
    localparam logic [AGE_W-1:0] LAT_C   = AGE_W'(RD_LATENCY);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(RD_DEPTH - 1);

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a >= LAT_C) ? LAT_C : a + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_SIZE-1:0]   r_tag_mem  [ENTRIES];
    logic [DATA_WIDTH-1:0] r_data_mem [ENTRIES];

    logic [ID_WIDTH-1:0]   r_q_id    [RD_DEPTH];
    logic [RDATA_W-1:0]    r_q_rdata [RD_DEPTH];
    logic [AGE_W-1:0]      r_q_age   [RD_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  r_aw_held;
    logic                  r_w_held;
    logic [LINE_W-1:0]     r_aw_line;
    logic [DATA_WIDTH-1:0] r_w_data;

    logic w_ready_stall;
    logic w_rvalid_mask;

`ifdef MEM_RESP_STALL_EN
    logic [2:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stall_cnt <= '0;
        else        r_stall_cnt <= r_stall_cnt + 3'd1;
    end

    assign w_ready_stall = (r_stall_cnt == 3'd7);
    assign w_rvalid_mask = (r_stall_cnt == 3'd3);
`else
    assign w_ready_stall = 1'b0;
    assign w_rvalid_mask = 1'b0;
`endif

    logic                   w_head_ready;
    logic                   w_rvalid;
    logic                   w_arready;
    logic                   w_push;
    logic                   w_pop;
    logic [INDEX_WIDTH-1:0] w_ar_idx;
    logic [TAG_SIZE-1:0]    w_ar_tag;
    logic                   w_ar_hit_valid;
    logic [TAG_SIZE-1:0]    w_rd_tag;
    logic [DATA_WIDTH-1:0]  w_rd_data;
    logic                   w_aw_ready;
    logic                   w_w_ready;
    logic                   w_aw_fire;
    logic                   w_w_fire;
    logic                   w_commit;
    logic [INDEX_WIDTH-1:0] w_wr_idx;
    logic [TAG_SIZE-1:0]    w_wr_tag;
    logic                   w_unused;

    // Head is presentable once it has aged RD_LATENCY cycles; the stall mask only hides it.
    assign w_head_ready = (r_count != '0) && (r_q_age[r_head] == LAT_C);
    assign w_rvalid     = w_head_ready & ~w_rvalid_mask;
    assign w_arready    = (r_count < DEPTH_C) & ~w_ready_stall;
    assign w_push       = bus.arvalid_i & w_arready;
    assign w_pop        = w_rvalid & bus.rready_i;

    // Invalid lines return the inverted request tag so the controller always sees a miss.
    assign w_ar_idx       = bus.araddr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_ar_tag       = bus.araddr_i[OFFSET_WIDTH + INDEX_WIDTH +: TAG_SIZE];
    assign w_ar_hit_valid = r_valid[w_ar_idx];
    assign w_rd_tag       = w_ar_hit_valid ? r_tag_mem[w_ar_idx]  : ~w_ar_tag;
    assign w_rd_data      = w_ar_hit_valid ? r_data_mem[w_ar_idx] : '0;

    assign w_aw_ready = ~r_aw_held & ~w_ready_stall;
    assign w_w_ready  = ~r_w_held  & ~w_ready_stall;
    assign w_aw_fire  = bus.awvalid_i & w_aw_ready;
    assign w_w_fire   = bus.wvalid_i  & w_w_ready;
    assign w_commit   = r_aw_held & r_w_held;
    assign w_wr_idx   = r_aw_line[INDEX_WIDTH-1:0];
    assign w_wr_tag   = r_aw_line[INDEX_WIDTH +: TAG_SIZE];

    assign bus.arready_o = w_arready;
    assign bus.rvalid_o  = w_rvalid;
    assign bus.rid_o     = w_head_ready ? r_q_id[r_head]    : '0;
    assign bus.rdata_o   = w_head_ready ? r_q_rdata[r_head] : '0;
    assign bus.awready_o = w_aw_ready;
    assign bus.wready_o  = w_w_ready;

    assign w_unused = ^{bus.awid_i, bus.wid_i, bus.araddr_i, bus.awaddr_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            for (int i = 0; i < RD_DEPTH; i++) r_q_age[i] <= '0;
        end else begin
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (w_pop)  r_head <= ptr_inc(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            // A freshly pushed slot already counts its acceptance cycle.
            for (int i = 0; i < RD_DEPTH; i++) begin
                if (w_push && (r_tail == PTR_W'(i))) r_q_age[i] <= AGE_W'(1);
                else                                 r_q_age[i] <= age_sat_inc(r_q_age[i]);
            end
            if (w_commit) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_aw_held         <= 1'b0;
                r_w_held          <= 1'b0;
            end else begin
                if (w_aw_fire) r_aw_held <= 1'b1;
                if (w_w_fire)  r_w_held  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_id[r_tail]    <= bus.arid_i;
            r_q_rdata[r_tail] <= {w_rd_tag, w_rd_data};
        end
        if (w_aw_fire) r_aw_line <= bus.awaddr_i[OFFSET_WIDTH +: LINE_W];
        if (w_w_fire)  r_w_data  <= bus.wdata_i;
        if (w_commit) begin
            r_tag_mem[w_wr_idx]  <= w_wr_tag;
            r_data_mem[w_wr_idx] <= r_w_data;
        end
    end
endmodule

// File: tb/tb_dram_cache_mem_responder.sv
// Bench for dram_cache_mem_responder: vector table, directed corner sequences and random traffic
// checked every cycle against a timestamped response-queue model of the memory.
module tb_dram_cache_mem_responder;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int TW = 16;
    localparam int RDW = TW + DW;
    localparam int RD_LATENCY = 4;
    localparam int RD_DEPTH = 8;

    logic clk;
    logic rst_n;

    dram_cache_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TAG_SIZE(TW)) u_if ();

    dram_cache_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TAG_SIZE(TW),
        .INDEX_WIDTH(10), .OFFSET_WIDTH(6), .RD_LATENCY(RD_LATENCY), .RD_DEPTH(RD_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: memory contents plus an ordered list of pending responses with acceptance times.
    typedef struct {
        logic [IW-1:0]  id;
        logic [RDW-1:0] rdata;
        int             acc;
    } rsp_t;

    rsp_t          mq[$];
    bit            m_valid [1024];
    logic [TW-1:0] m_tag   [1024];
    logic [DW-1:0] m_data  [1024];
    bit            m_aw_held;
    bit            m_w_held;
    logic [AW-1:0] m_aw_addr;
    logic [DW-1:0] m_w_data;
    int            cyc = 0;

    logic           s_rvalid, s_arready, s_awready, s_wready;
    logic [IW-1:0]  s_rid;
    logic [RDW-1:0] s_rdata;
    int             s_cyc;

    task automatic step(input logic arv, input logic [IW-1:0] id, input logic [AW-1:0] araddr, input logic rr,
                        input logic awv, input logic [AW-1:0] awaddr, input logic wv, input logic [DW-1:0] wdata);
        bit   exp_rv, exp_ar, exp_aw, exp_w;
        int   idx, ctag, widx;
        rsp_t e;
        u_if.arvalid_i = arv;  u_if.arid_i = id;  u_if.araddr_i = araddr; u_if.rready_i = rr;
        u_if.awvalid_i = awv;  u_if.awid_i = id;  u_if.awaddr_i = awaddr;
        u_if.wvalid_i  = wv;   u_if.wid_i  = id;  u_if.wdata_i  = wdata;
        #1;
        s_rvalid = u_if.rvalid_o;   s_arready = u_if.arready_o;
        s_awready = u_if.awready_o; s_wready = u_if.wready_o;
        s_rid = u_if.rid_o;         s_rdata = u_if.rdata_o;
        s_cyc = cyc;
        exp_ar = (mq.size() < RD_DEPTH);
        exp_rv = (mq.size() > 0) && (cyc >= mq[0].acc + RD_LATENCY);
        exp_aw = !m_aw_held;
        exp_w  = !m_w_held;
        chk("arready", RDW'(s_arready), RDW'(exp_ar));
        chk("rvalid",  RDW'(s_rvalid),  RDW'(exp_rv));
        chk("awready", RDW'(s_awready), RDW'(exp_aw));
        chk("wready",  RDW'(s_wready),  RDW'(exp_w));
        if (exp_rv) begin
            chk("rid",   RDW'(s_rid), RDW'(mq[0].id));
            chk("rdata", s_rdata,     mq[0].rdata);
        end
        if (arv && exp_ar) begin
            idx  = int'((araddr >> 6) % 1024);
            ctag = int'(araddr >> 16);
            e.id  = id;
            e.acc = cyc;
            if (m_valid[idx]) e.rdata = {m_tag[idx], m_data[idx]};
            else              e.rdata = {~TW'(ctag), DW'(0)};
            mq.push_back(e);
        end
        if (exp_rv && rr) void'(mq.pop_front());
        if (m_aw_held && m_w_held) begin
            widx = int'((m_aw_addr >> 6) % 1024);
            m_valid[widx] = 1'b1;
            m_tag[widx]   = TW'(m_aw_addr >> 16);
            m_data[widx]  = m_w_data;
            m_aw_held = 1'b0;
            m_w_held  = 1'b0;
        end else begin
            if (awv && exp_aw) begin m_aw_held = 1'b1; m_aw_addr = awaddr; end
            if (wv && exp_w)   begin m_w_held  = 1'b1; m_w_data  = wdata;  end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, '0, rr, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        u_if.arvalid_i = 1'b0; u_if.rready_i = 1'b0; u_if.awvalid_i = 1'b0; u_if.wvalid_i = 1'b0;
        u_if.arid_i = '0; u_if.araddr_i = '0; u_if.awid_i = '0; u_if.awaddr_i = '0;
        u_if.wid_i = '0; u_if.wdata_i = '0;
        mq.delete();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_aw_held = 1'b0;
        m_w_held  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rvalid",  RDW'(u_if.rvalid_o),  RDW'(0));
        chk("rst_rid",     RDW'(u_if.rid_o),     RDW'(0));
        chk("rst_rdata",   u_if.rdata_o,         RDW'(0));
        chk("rst_arready", RDW'(u_if.arready_o), RDW'(1));
        chk("rst_awready", RDW'(u_if.awready_o), RDW'(1));
        chk("rst_wready",  RDW'(u_if.wready_o),  RDW'(1));
        @(negedge clk);
    endtask

    task automatic do_fill(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        step(1'b0, '0, '0, 1'b1, 1'b1, addr, 1'b1, data);
        idle(1'b1);
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           output logic [IW-1:0] rid, output logic [RDW-1:0] rdata, output int lat);
        bit acc, got;
        int h;
        acc = 1'b0; got = 1'b0; h = 0; lat = -1; rid = '0; rdata = '0;
        for (int n = 0; n < 20 && !acc; n++) begin
            step(1'b1, id, addr, 1'b1, 1'b0, '0, 1'b0, '0);
            if (s_arready) begin acc = 1'b1; h = s_cyc; end
        end
        for (int n = 0; n < 20 && acc && !got; n++) begin
            idle(1'b1);
            if (s_rvalid) begin got = 1'b1; lat = s_cyc - h; rid = s_rid; rdata = s_rdata; end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL read_timeout addr=%h got=none expected=response", addr);
        end
    endtask

    typedef struct {
        bit             is_fill;
        logic [AW-1:0]  addr;
        logic [IW-1:0]  id;
        logic [DW-1:0]  wdata;
        logic [RDW-1:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [IW-1:0]  rid;
        logic [RDW-1:0] rdata;
        int             lat;
        int             nacc, nrv;
        bit             acc9;
        logic [IW-1:0]  got_ids[$];
        logic [RDW-1:0] got5[$];
        logic [AW-1:0]  a_rd, a_wr;

        tbl[0] = '{1'b0, 32'h0000_0040, 4'd1, 64'h0,                    {16'hFFFF, 64'h0}};
        tbl[1] = '{1'b1, 32'h0001_2340, 4'd0, 64'hA5A5_0000_0000_0001, {16'h0000, 64'h0}};
        tbl[2] = '{1'b0, 32'h0001_2340, 4'd3, 64'h0,                    {16'h0001, 64'hA5A5_0000_0000_0001}};
        tbl[3] = '{1'b0, 32'h0002_2340, 4'd5, 64'h0,                    {16'h0001, 64'hA5A5_0000_0000_0001}};
        tbl[4] = '{1'b1, 32'h0003_0080, 4'd0, 64'h1122_3344_5566_7788, {16'h0000, 64'h0}};
        tbl[5] = '{1'b0, 32'h0003_0080, 4'd7, 64'h0,                    {16'h0003, 64'h1122_3344_5566_7788}};
        tbl[6] = '{1'b0, 32'h0003_00C0, 4'd8, 64'h0,                    {16'hFFFC, 64'h0}};
        tbl[7] = '{1'b0, 32'h0001_2340, 4'd2, 64'h0,                    {16'h0001, 64'hA5A5_0000_0000_0001}};

        do_reset();

        for (int k = 0; k < 8; k++) begin
            if (tbl[k].is_fill) begin
                do_fill(tbl[k].addr, tbl[k].wdata);
            end else begin
                do_read(tbl[k].id, tbl[k].addr, rid, rdata, lat);
                chk($sformatf("tbl%0d_rid", k),   RDW'(rid), RDW'(tbl[k].id));
                chk($sformatf("tbl%0d_rdata", k), rdata,     tbl[k].exp);
                chk($sformatf("tbl%0d_lat", k),   RDW'(lat), RDW'(RD_LATENCY));
            end
        end

        // Nine back-to-back reads against a stalled R channel.
        nacc = 0;
        for (int i = 0; i < 9; i++) begin
            a_rd = {16'h0000, 10'(i + 16), 6'h00};
            step(1'b1, IW'(i), a_rd, 1'b0, 1'b0, '0, 1'b0, '0);
            if (s_arready) nacc++;
            if (i == 8) chk("full_arready9", RDW'(s_arready), RDW'(0));
        end
        chk("full_accepted", RDW'(nacc), RDW'(8));
        acc9 = 1'b0;
        a_rd = {16'h0000, 10'(24), 6'h00};
        for (int n = 0; n < 60 && got_ids.size() < 9; n++) begin
            step(!acc9, 4'd8, a_rd, 1'b1, 1'b0, '0, 1'b0, '0);
            if (!acc9 && s_arready) acc9 = 1'b1;
            if (s_rvalid) got_ids.push_back(s_rid);
        end
        chk("drain_count", RDW'(got_ids.size()), RDW'(9));
        for (int i = 0; i < got_ids.size(); i++)
            chk($sformatf("drain_rid%0d", i), RDW'(got_ids[i]), RDW'(i));

        // W three cycles ahead of AW; a read in the commit cycle sees the old line.
        a_wr = 32'h0004_2340;
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1, 64'hDEAD_BEEF_0000_0005);
        idle(1'b1);
        idle(1'b1);
        chk("w_hold_wready", RDW'(s_wready), RDW'(0));
        step(1'b0, '0, '0, 1'b1, 1'b1, a_wr, 1'b0, '0);
        step(1'b1, 4'd9,  a_wr, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("commit_cycle_arready", RDW'(s_arready), RDW'(1));
        step(1'b1, 4'd10, a_wr, 1'b1, 1'b0, '0, 1'b0, '0);
        for (int n = 0; n < 20 && got5.size() < 2; n++) begin
            idle(1'b1);
            if (s_rvalid) got5.push_back(s_rdata);
        end
        chk("commit_resp_count", RDW'(got5.size()), RDW'(2));
        if (got5.size() == 2) begin
            chk("commit_same_cycle_old", got5[0], {16'h0001, 64'hA5A5_0000_0000_0001});
            chk("commit_next_cycle_new", got5[1], {16'h0004, 64'hDEAD_BEEF_0000_0005});
        end

        // Reset with reads in flight drops them and invalidates the array.
        for (int i = 0; i < 3; i++)
            step(1'b1, IW'(i + 1), {16'h0000, 10'(i + 40), 6'h00}, 1'b0, 1'b0, '0, 1'b0, '0);
        idle(1'b0);
        do_reset();
        nrv = 0;
        for (int n = 0; n < 12; n++) begin
            idle(1'b1);
            if (s_rvalid) nrv++;
        end
        chk("rst_no_rvalid", RDW'(nrv), RDW'(0));
        do_read(4'd4, 32'h0001_2340, rid, rdata, lat);
        chk("rst_invalid_rid",   RDW'(rid), RDW'(4));
        chk("rst_invalid_rdata", rdata,     {16'hFFFE, 64'h0});

        // Random mixed traffic over a few aliased indices.
        for (int n = 0; n < 1500; n++) begin
            a_rd = {16'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 6'($urandom)};
            a_wr = {16'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 6'($urandom)};
            step($urandom_range(0, 99) < 50, IW'($urandom), a_rd, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 40, a_wr, $urandom_range(0, 99) < 40, {$urandom, $urandom});
        end
        for (int n = 0; n < 40; n++) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
